// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StWrite
   } state_e;

   localparam int unsigned OFFSET_W = 4;
   localparam int unsigned LINE_W   = 128;
   localparam int unsigned WORD_W   = 64;
   localparam int unsigned ADDR_W   = 64;

   // Line index, right-aligned; the caller truncates to its index width.
   function automatic logic [ADDR_W-1:0] get_index(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned       iw);
      logic [ADDR_W-1:0] mask;
      mask = (64'd1 << iw) - 64'd1;
      return (addr >> OFFSET_W) & mask;
   endfunction

   // Tag, right-aligned; the caller truncates to its tag width.
   function automatic logic [ADDR_W-1:0] get_tag(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned       iw);
      return addr >> (OFFSET_W + iw);
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays with a combinational lookup and synchronous fill/update ports.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int unsigned NUM_LINES = 16,
   parameter int unsigned IW        = $clog2(NUM_LINES),
   parameter int unsigned TAG_W     = ADDR_W - OFFSET_W - IW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IW-1:0]     idx_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              word_sel_i,
   output logic              hit_o,
   output logic [WORD_W-1:0] word_o,
   input  logic              fill_en_i,
   input  logic [LINE_W-1:0] fill_data_i,
   input  logic              upd_en_i,
   input  logic [WORD_W-1:0] upd_data_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];
   logic [LINE_W-1:0]    line;

   // Lookup of the addressed line and selection of the requested 64-bit word.
   always_comb begin
      line   = data_q[idx_i];
      hit_o  = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
      word_o = word_sel_i ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
   end

   // Valid bits are the only reset state; a fill marks the line valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (fill_en_i) begin
         valid_q[idx_i] <= 1'b1;
      end
   end

   // Tag and data arrays: whole-line fill or single-word store update.
   always_ff @(posedge clk) begin
      if (fill_en_i) begin
         data_q[idx_i] <= fill_data_i;
         tag_q[idx_i]  <= tag_i;
      end else if (upd_en_i) begin
         if (word_sel_i) begin
            data_q[idx_i][LINE_W-1:WORD_W] <= upd_data_i;
         end else begin
            data_q[idx_i][WORD_W-1:0] <= upd_data_i;
         end
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int unsigned NUM_LINES    = 16,
   parameter int unsigned MISS_LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [WORD_W-1:0]   cpu_wdata_i,
   input  logic                cpu_read_i,
   input  logic                cpu_write_i,
   output logic [WORD_W-1:0]   cpu_rdata_o,
   output logic                cpu_stall_o,
   output logic [ADDR_W-1:0]   mem_address_o,
   output logic [WORD_W-1:0]   mem_write_data_o,
   output logic                mem_write_o,
   output logic                mem_read_o,
   input  logic [LINE_W-1:0]   mem_block_data_i,
   output logic [31:0]         hit_count_o,
   output logic [31:0]         miss_count_o
);

   localparam int unsigned IW       = $clog2(NUM_LINES);
   localparam int unsigned TAG_W    = ADDR_W - OFFSET_W - IW;
   localparam int unsigned CNT_W    = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_LATENCY - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]      idx;
   logic [TAG_W-1:0]   tag;
   logic               lk_hit;
   logic [WORD_W-1:0]  lk_word;
   logic               stall;
   logic [WORD_W-1:0]  rdata;
   logic               fill_en;
   logic               upd_en;
   logic               hit_evt;
   logic               miss_evt;

   assign idx = IW'(get_index(cpu_addr_i, IW));
   assign tag = TAG_W'(get_tag(cpu_addr_i, IW));

   dcache_line_store #(
      .NUM_LINES (NUM_LINES),
      .IW        (IW),
      .TAG_W     (TAG_W)
   ) u_line_store (
      .clk         (clk),
      .rst_n       (rst_n),
      .idx_i       (idx),
      .tag_i       (tag),
      .word_sel_i  (cpu_addr_i[3]),
      .hit_o       (lk_hit),
      .word_o      (lk_word),
      .fill_en_i   (fill_en),
      .fill_data_i (mem_block_data_i),
      .upd_en_i    (upd_en),
      .upd_data_i  (cpu_wdata_i)
   );

   // State and fill-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, memory-side strobes and CPU-side handshake.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      stall            = 1'b0;
      rdata            = '0;
      mem_read_o       = 1'b0;
      mem_write_o      = 1'b0;
      mem_address_o    = '0;
      mem_write_data_o = '0;
      fill_en          = 1'b0;
      upd_en           = 1'b0;
      hit_evt          = 1'b0;
      miss_evt         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cpu_write_i) begin
               // Stores win over a simultaneous load.
               stall   = 1'b1;
               state_d = StWrite;
            end else if (cpu_read_i) begin
               if (lk_hit) begin
                  rdata   = lk_word;
                  hit_evt = 1'b1;
               end else begin
                  stall    = 1'b1;
                  cnt_d    = '0;
                  miss_evt = 1'b1;
                  state_d  = StFill;
               end
            end
         end
         StFill: begin
            stall         = 1'b1;
            mem_read_o    = 1'b1;
            mem_address_o = {cpu_addr_i[ADDR_W-1:OFFSET_W], 4'h0};
            cnt_d         = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               fill_en = 1'b1;
               state_d = StIdle;
            end
         end
         StWrite: begin
            mem_write_o      = 1'b1;
            mem_address_o    = {cpu_addr_i[ADDR_W-1:3], 3'h0};
            mem_write_data_o = cpu_wdata_i;
            // No allocation on a store miss; only an existing line is refreshed.
            upd_en           = lk_hit;
            hit_evt          = lk_hit;
            miss_evt         = ~lk_hit;
            state_d          = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Stall is forced low while reset is held so a held request cannot stall the pipe.
   assign cpu_stall_o = stall & rst_n;
   assign cpu_rdata_o = rdata;

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Free-running wrap-around hit/miss counters.
   always_comb begin
      hit_cnt_d  = hit_cnt_q + {31'd0, hit_evt};
      miss_cnt_d = miss_cnt_q + {31'd0, miss_evt};
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;
`else
   logic unused_evt;
   assign unused_evt   = hit_evt ^ miss_evt;
   assign hit_count_o  = '0;
   assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: memory model, transaction-level cache model
// compared every cycle, plus directed loads/stores with hand-computed expectations.
module tb_dcache_controller;

   localparam int unsigned NUM_LINES    = 16;
   localparam int unsigned MISS_LATENCY = 2;
`ifdef DCACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [63:0]   cpu_addr = '0;
   logic [63:0]   cpu_wdata = '0;
   logic          cpu_read = 1'b0;
   logic          cpu_write = 1'b0;
   logic [63:0]   rdata;
   logic          stall;
   logic [63:0]   mem_address;
   logic [63:0]   mem_wdata;
   logic          mem_write;
   logic          mem_read;
   logic [127:0]  mem_block;
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;

   int n_cmp = 0;
   int n_err = 0;

   dcache_controller #(
      .NUM_LINES    (NUM_LINES),
      .MISS_LATENCY (MISS_LATENCY)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu_addr_i       (cpu_addr),
      .cpu_wdata_i      (cpu_wdata),
      .cpu_read_i       (cpu_read),
      .cpu_write_i      (cpu_write),
      .cpu_rdata_o      (rdata),
      .cpu_stall_o      (stall),
      .mem_address_o    (mem_address),
      .mem_write_data_o (mem_wdata),
      .mem_write_o      (mem_write),
      .mem_read_o       (mem_read),
      .mem_block_data_i (mem_block),
      .hit_count_o      (hit_count),
      .miss_count_o     (miss_count)
   );

   always #5 clk = ~clk;

   // data_memory: 128 words addressed by address[9:3].
   logic [63:0] mem [128];
   logic        mem_loaded = 1'b0;

   assign mem_block = {mem[{mem_address[9:4], 1'b1}], mem[{mem_address[9:4], 1'b0}]};

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 128; i++) mem[i] <= 64'h1000 + 64'(i);
         mem[0] <= 64'd50;
         mem[1] <= 64'd21;
         mem[2] <= 64'd88;
         mem[3] <= 64'd1;
         mem_loaded <= 1'b1;
      end else if (mem_write) begin
         mem[mem_address[9:3]] <= mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Cache model: which line address each index holds; data always equals memory
   // because every store is written through and refreshes a cached copy.
   bit          m_valid [NUM_LINES];
   logic [59:0] m_line  [NUM_LINES];
   int          m_fill_left = 0;
   bit          m_write_pend = 1'b0;
   int unsigned m_hits = 0;
   int unsigned m_misses = 0;

   always @(negedge clk) begin : model_cmp
      logic [63:0] a;
      int unsigned idx;
      bit          hit;
      a   = cpu_addr;
      idx = int'((a >> 4) & 64'(NUM_LINES - 1));
      hit = m_valid[idx] && (m_line[idx] == a[63:4]);
      if (!rst_n) begin
         chk("m_rst_stall", 64'(stall), 64'd0);
         chk("m_rst_mem_read", 64'(mem_read), 64'd0);
         chk("m_rst_mem_write", 64'(mem_write), 64'd0);
         chk("m_rst_rdata", rdata, 64'd0);
         chk("m_rst_hits", 64'(hit_count), 64'd0);
         chk("m_rst_misses", 64'(miss_count), 64'd0);
         foreach (m_valid[i]) m_valid[i] = 1'b0;
         m_fill_left  = 0;
         m_write_pend = 1'b0;
         m_hits       = 0;
         m_misses     = 0;
      end else begin
         chk("m_hit_count", 64'(hit_count), STATS ? 64'(m_hits) : 64'd0);
         chk("m_miss_count", 64'(miss_count), STATS ? 64'(m_misses) : 64'd0);
         if (m_fill_left > 0) begin
            chk("m_fill_stall", 64'(stall), 64'd1);
            chk("m_fill_mem_read", 64'(mem_read), 64'd1);
            chk("m_fill_mem_write", 64'(mem_write), 64'd0);
            chk("m_fill_addr", mem_address, {a[63:4], 4'h0});
            m_fill_left--;
            if (m_fill_left == 0) begin
               m_valid[idx] = 1'b1;
               m_line[idx]  = a[63:4];
            end
         end else if (m_write_pend) begin
            chk("m_wr_stall", 64'(stall), 64'd0);
            chk("m_wr_mem_write", 64'(mem_write), 64'd1);
            chk("m_wr_mem_read", 64'(mem_read), 64'd0);
            chk("m_wr_addr", mem_address, {a[63:3], 3'h0});
            chk("m_wr_data", mem_wdata, cpu_wdata);
            if (hit) m_hits++;
            else m_misses++;
            m_write_pend = 1'b0;
         end else begin
            chk("m_idle_mem_read", 64'(mem_read), 64'd0);
            chk("m_idle_mem_write", 64'(mem_write), 64'd0);
            chk("m_idle_addr", mem_address, 64'd0);
            if (cpu_write) begin
               chk("m_st_stall", 64'(stall), 64'd1);
               m_write_pend = 1'b1;
            end else if (cpu_read) begin
               if (hit) begin
                  chk("m_ld_hit_stall", 64'(stall), 64'd0);
                  chk("m_ld_hit_data", rdata, mem[a[9:3]]);
                  m_hits++;
               end else begin
                  chk("m_ld_miss_stall", 64'(stall), 64'd1);
                  m_fill_left = MISS_LATENCY;
                  m_misses++;
               end
            end else begin
               chk("m_quiet_stall", 64'(stall), 64'd0);
            end
         end
      end
   end

   task automatic do_load(input logic [63:0] addr, input logic [63:0] exp_data,
                          input int exp_stall, input int exp_rd);
      int          stalls;
      int          rds;
      bit          done;
      logic [63:0] fill_addr;
      @(posedge clk); #1;
      cpu_addr  = addr;
      cpu_read  = 1'b1;
      cpu_write = 1'b0;
      stalls    = 0;
      rds       = 0;
      done      = 1'b0;
      fill_addr = '0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (mem_read) begin
            rds++;
            fill_addr = mem_address;
         end
         if (stall) stalls++;
         else done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL load_timeout: addr 0x%0h still stalled after 20 cycles", addr);
      end else begin
         chk("load_data", rdata, exp_data);
      end
      chk("load_stalls", 64'(stalls), 64'(exp_stall));
      chk("load_mem_read_cycles", 64'(rds), 64'(exp_rd));
      if (rds > 0) chk("load_fill_addr", fill_addr, {addr[63:4], 4'h0});
      @(posedge clk); #1;
      cpu_read = 1'b0;
   endtask

   task automatic do_store(input logic [63:0] addr, input logic [63:0] data);
      int          stalls;
      int          wrs;
      int          rds;
      bit          done;
      logic [63:0] wa;
      logic [63:0] wd;
      @(posedge clk); #1;
      cpu_addr  = addr;
      cpu_wdata = data;
      cpu_write = 1'b1;
      cpu_read  = 1'b0;
      stalls    = 0;
      wrs       = 0;
      rds       = 0;
      done      = 1'b0;
      wa        = '0;
      wd        = '0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (mem_read) rds++;
         if (mem_write) begin
            wrs++;
            wa = mem_address;
            wd = mem_wdata;
         end
         if (stall) stalls++;
         else done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL store_timeout: addr 0x%0h still stalled after 20 cycles", addr);
      end
      chk("store_stalls", 64'(stalls), 64'd1);
      chk("store_wr_pulses", 64'(wrs), 64'd1);
      chk("store_wr_addr", wa, {addr[63:3], 3'h0});
      chk("store_wr_data", wd, data);
      chk("store_no_fill", 64'(rds), 64'd0);
      @(posedge clk); #1;
      cpu_write = 1'b0;
      @(negedge clk);
      chk("store_wr_after", 64'(mem_write), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_stall", 64'(stall), 64'd0);
      chk("reset_rdata", rdata, 64'd0);
      chk("reset_mem_read", 64'(mem_read), 64'd0);
      chk("reset_hit_count", 64'(hit_count), 64'd0);
      rst_n = 1'b1;

      // Read miss, then same-line hit.
      do_load(64'h1001_0008, 64'd21, 3, 2);
      do_load(64'h1001_0000, 64'd50, 0, 0);
      // Store miss does not allocate; following load misses and sees the new word.
      do_store(64'h1001_0018, 64'd7);
      do_load(64'h1001_0018, 64'd7, 3, 2);
      // Store hit updates the line in place.
      do_store(64'h1001_0000, 64'd99);
      do_load(64'h1001_0000, 64'd99, 0, 0);
      // Conflict eviction on index 0.
      do_load(64'h1001_0100, 64'h1020, 3, 2);
      do_load(64'h1001_0000, 64'd99, 3, 2);

      // Back-to-back hits on consecutive cycles.
      @(posedge clk); #1;
      cpu_addr = 64'h1001_0000;
      cpu_read = 1'b1;
      @(negedge clk);
      chk("b2b_0_stall", 64'(stall), 64'd0);
      chk("b2b_0_data", rdata, 64'd99);
      @(posedge clk); #1;
      cpu_addr = 64'h1001_0008;
      @(negedge clk);
      chk("b2b_1_stall", 64'(stall), 64'd0);
      chk("b2b_1_data", rdata, 64'd21);
      @(posedge clk); #1;
      cpu_read = 1'b0;
      @(negedge clk);
      chk("stats_hits", 64'(hit_count), STATS ? 64'd9 : 64'd0);
      chk("stats_misses", 64'(miss_count), STATS ? 64'd5 : 64'd0);

      // Reset asserted during the first FILL cycle.
      @(posedge clk); #1;
      cpu_addr = 64'h1001_0020;
      cpu_read = 1'b1;
      @(negedge clk);
      chk("midfill_req_stall", 64'(stall), 64'd1);
      @(posedge clk); #1;
      chk("midfill_mem_read", 64'(mem_read), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midfill_rst_stall", 64'(stall), 64'd0);
      chk("midfill_rst_mem_read", 64'(mem_read), 64'd0);
      chk("midfill_rst_rdata", rdata, 64'd0);
      chk("midfill_rst_hits", 64'(hit_count), 64'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      cpu_read = 1'b0;
      do_load(64'h1001_0020, 64'h1004, 3, 2);
      // Line 0 was invalidated by reset.
      do_load(64'h1001_0000, 64'd99, 3, 2);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage and `data_memory`. It serves 64-bit loads and stores from the CPU. On a load miss it fills one 16-byte line from the 128-bit block-read port. Stores are forwarded to memory as one 64-bit write each. The pipeline is stalled through `cpu_stall` while a fill or write is in progress.

## Interface
- `NUM_LINES`, 16: number of cache lines; must be a power of two and at least 2.
- `MISS_LATENCY`, 2: cycles `mem_read` is held before the block is captured; must be at least 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_addr` in 64: byte address; bits [2:0] are ignored.
- `cpu_wdata` in 64: store data.
- `cpu_read` in 1: load request.
- `cpu_write` in 1: store request.
- `cpu_rdata` out 64: load data; valid when `cpu_read`=1 and `cpu_stall`=0.
- `cpu_stall` out 1: CPU must hold its request while this is high.
- `mem_address` out 64: address to `data_memory`.
- `mem_write_data` out 64: store data to memory.
- `mem_write` out 1: memory write strobe.
- `mem_read` out 1: block read enable.
- `mem_block_data` in 128: block from memory; combinational with `mem_address`.
- `hit_count`, `miss_count` out 32 each: statistics counters (see Configuration).

## Operation
- Address split: offset = `cpu_addr`[3:0]; word select = bit [3] (0 selects block[63:0], 1 selects block[127:64]).
- Index = `cpu_addr`[4+IW-1:4], where IW = log2(`NUM_LINES`); tag = `cpu_addr`[63:4+IW].
- Each line holds a valid bit, a tag and 128 data bits.
- FSM states: IDLE, FILL, WRITE.
- IDLE, load hit: `cpu_rdata` is the selected word, combinational; `cpu_stall`=0; state stays IDLE.
- IDLE, load miss: `cpu_stall`=1; fill counter cleared; go to FILL.
- IDLE, store: `cpu_stall`=1; go to WRITE.
- If `cpu_read` and `cpu_write` are both high, the store has priority.
- FILL:
  - `mem_read`=1; `mem_address`={`cpu_addr`[63:4],4'h0}; `cpu_stall`=1.
  - The counter increments every cycle.
  - In the cycle the counter reaches `MISS_LATENCY`-1, `mem_block_data` is written into the line, the tag is written, valid is set, and the FSM returns to IDLE.
  - The retried load then hits.
- WRITE:
  - `mem_write`=1; `mem_address`={`cpu_addr`[63:3],3'h0}; `mem_write_data`=`cpu_wdata`; `cpu_stall`=0.
  - On a tag hit, the selected word of the line is updated at the same edge. A miss does not allocate a line.
  - Return to IDLE.
- Outside FILL and WRITE, `mem_read`, `mem_write`, `mem_address` and `mem_write_data` are 0.
- Reset, including reset asserted mid-FILL or mid-WRITE:
  - All valid bits are cleared; state goes to IDLE; the fill counter goes to 0.
  - No line is marked valid; `cpu_stall`=0; `cpu_rdata`=0.
  - Data and tag arrays need no reset.

## Timing
- Load hit: 0 stall cycles; data is available in the request cycle.
- Load miss: `MISS_LATENCY`+1 stall cycles; data appears in the first cycle after FILL.
- Store, hit or miss: 1 stall cycle. `mem_write` is high for exactly one cycle, the cycle after the request, and memory captures the data at the end of that cycle.
- The CPU must hold `cpu_addr`, `cpu_wdata` and the request signals stable while `cpu_stall`=1.
- Back-to-back requests are accepted every cycle when no stall is active.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments on each IDLE load hit and each WRITE-state tag hit.
  - `miss_count` increments on each IDLE-to-FILL transition and each WRITE-state tag miss.
  - Both counters wrap at 2^32 and reset to 0.
- `DCACHE_STATS_EN` undefined: no counter logic; `hit_count` and `miss_count` are tied to 0.

## Structure
- `dcache_pkg` holds:
  - the state enum {IDLE, FILL, WRITE};
  - `OFFSET_W`=4, `LINE_W`=128, `WORD_W`=64;
  - functions for index and tag extraction.
- Sub-module `dcache_line_store`: valid/tag/data arrays with a combinational lookup (hit, word out) and synchronous line-fill and word-update ports. The FSM stays in `dcache_controller`.

## Test plan
Defaults apply (`NUM_LINES`=16, `MISS_LATENCY`=2). Memory is preloaded with words 50, 21, 88, 1 starting at byte 0x0000 (`address`[9:0]=0x000).
- Read miss: after reset, load 0x10010008 -> `cpu_stall` high for 3 cycles; `mem_read`=1 with `mem_address`=0x10010000 for 2 cycles; then `cpu_rdata`=21 with stall 0.
- Same-line hit: then load 0x10010000 -> stall 0, `cpu_rdata`=50, `mem_read` stays 0.
- Store miss, no allocate: store 7 to 0x10010018 -> 1 stall cycle; one `mem_write` pulse with address 0x10010018 and data 7; no FILL. Then load 0x10010018 -> miss, returns 7.
- Store hit: store 99 to 0x10010000 -> `mem_write` pulse. Then load 0x10010000 -> hit with 0 stall, returns 99.
- Conflict eviction: load 0x10010100 (same index 0) -> miss, fills the line. Then load 0x10010000 -> miss again and refills, returning 99.
- Reset mid-fill: assert `rst_n`=0 during FILL cycle 1 -> `cpu_stall`, `mem_read`=0 immediately. After release, load the same address -> full miss sequence again.
